// File: rtl/dfx_mailbox_pkg.sv
// Shared constants and types for the host/MCU mailbox bridge: register map,
// status bit positions, AXI response codes, FSM states and address decode types.
package dfx_mailbox_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Word offsets inside a channel's 16-byte window
    localparam logic [1:0] OFF_IN_DATA  = 2'd0;
    localparam logic [1:0] OFF_OUT_DATA = 2'd1;
    localparam logic [1:0] OFF_STATUS   = 2'd2;
    localparam logic [1:0] OFF_RSVD     = 2'd3;

    localparam logic [11:0] ADDR_ID     = 12'h400;
    localparam logic [11:0] ADDR_IRQ_EN = 12'h404;
    localparam logic [31:0] ID_BASE     = 32'h4D42_0000;

    localparam int ST_IN_FULL    = 0;
    localparam int ST_OUT_FULL   = 1;
    localparam int ST_IN_TIMEOUT = 2;

    typedef enum logic {W_IDLE, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

    typedef enum logic [2:0] {
        DEC_IN, DEC_OUT, DEC_STATUS, DEC_RSVD, DEC_ID, DEC_IRQ_EN, DEC_ERR
    } dec_kind_e;

    typedef struct packed {
        dec_kind_e  kind;
        logic [5:0] ch;
    } dec_t;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/dfx_mailbox_channel.sv
// One mailbox channel: inbound/outbound word, FULL flags, sticky inbound timeout.
// Latency: flags update one cycle after the causing write/read/handshake.
// Backpressure: inbound valid is IN_FULL; outbound ready is registered ~OUT_FULL.
module dfx_mailbox_channel
    import dfx_mailbox_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_wr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    input  logic        tmo_clr,
    input  logic        out_rd,
    output logic [31:0] mcu_in_data,
    output logic        mcu_in_valid,
    input  logic        mcu_in_ready,
    input  logic [31:0] mcu_out_data,
    input  logic        mcu_out_valid,
    output logic        mcu_out_ready,
    output logic        in_full,
    output logic        out_full,
    output logic        in_timeout,
    output logic [31:0] out_word
);

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYC);

    logic [31:0] in_word;
    logic [15:0] cnt;
    logic        out_rdy;
    logic        out_hs;
    logic        out_full_n;
    logic        tmo_set;

    assign out_hs     = mcu_out_valid && out_rdy;
    assign tmo_set    = in_full && (cnt == TMO - 16'd1);
    // A host read only clears when full; a push is only taken when empty, so the two never collide
    assign out_full_n = out_hs ? 1'b1 : (out_rd ? 1'b0 : out_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_word    <= '0;
            in_full    <= 1'b0;
            out_word   <= '0;
            out_full   <= 1'b0;
            out_rdy    <= 1'b0;
            cnt        <= '0;
            in_timeout <= 1'b0;
        end else begin
            if (in_wr && !in_full) begin
                in_word <= strb_merge(in_word, wr_data, wr_strb);
                in_full <= 1'b1;
            end else if (in_full && mcu_in_ready) begin
                in_full <= 1'b0;
            end
            if (out_hs)
                out_word <= mcu_out_data;
            out_full <= out_full_n;
            out_rdy  <= !out_full_n;
            if (!in_full)
                cnt <= '0;
            else if (cnt != TMO)
                cnt <= cnt + 16'd1;
            in_timeout <= tmo_set | (in_timeout & ~tmo_clr);
        end
    end

    assign mcu_in_data   = in_word;
    assign mcu_in_valid  = in_full;
    assign mcu_out_ready = out_rdy;

endmodule

// File: rtl/dfx_mailbox_bridge.sv
// AXI4-Lite slave exposing NUM_CH host<->MCU mailboxes plus ID/IRQ_EN registers.
// Latency: bvalid 2 cycles after last of AW/W accepted; rvalid 1 cycle after AR.
// Backpressure: one outstanding write and one read; ready low until response taken.
module dfx_mailbox_bridge
    import dfx_mailbox_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int ADDR_W      = 12
) (
    input  logic                 AxiBusClock,
    input  logic                 xAxiBusReset_n,
    input  logic [ADDR_W-1:0]    s_axi_awaddr,
    input  logic                 s_axi_awvalid,
    output logic                 s_axi_awready,
    input  logic [31:0]          s_axi_wdata,
    input  logic [3:0]           s_axi_wstrb,
    input  logic                 s_axi_wvalid,
    output logic                 s_axi_wready,
    output logic [1:0]           s_axi_bresp,
    output logic                 s_axi_bvalid,
    input  logic                 s_axi_bready,
    input  logic [ADDR_W-1:0]    s_axi_araddr,
    input  logic                 s_axi_arvalid,
    output logic                 s_axi_arready,
    output logic [31:0]          s_axi_rdata,
    output logic [1:0]           s_axi_rresp,
    output logic                 s_axi_rvalid,
    input  logic                 s_axi_rready,
    output logic [NUM_CH*32-1:0] mcu_in_data,
    output logic [NUM_CH-1:0]    mcu_in_valid,
    input  logic [NUM_CH-1:0]    mcu_in_ready,
    input  logic [NUM_CH*32-1:0] mcu_out_data,
    input  logic [NUM_CH-1:0]    mcu_out_valid,
    output logic [NUM_CH-1:0]    mcu_out_ready,
    output logic                 host_irq
);

    function automatic dec_t decode(input logic [ADDR_W-1:2] a);
        dec_t d;
        d.kind = DEC_ERR;
        d.ch   = a[9:4];
        if (a[ADDR_W-1:10] == '0) begin
            if (int'(a[9:4]) < NUM_CH) begin
                case (a[3:2])
                    OFF_IN_DATA:  d.kind = DEC_IN;
                    OFF_OUT_DATA: d.kind = DEC_OUT;
                    OFF_STATUS:   d.kind = DEC_STATUS;
                    OFF_RSVD:     d.kind = DEC_RSVD;
                endcase
            end
        end else if ({a, 2'b00} == ADDR_W'(ADDR_ID)) begin
            d.kind = DEC_ID;
        end else if ({a, 2'b00} == ADDR_W'(ADDR_IRQ_EN)) begin
            d.kind = DEC_IRQ_EN;
        end
        return d;
    endfunction

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    wr_state_e w_state, w_state_n;
    rd_state_e r_state, r_state_n;
    logic aw_held, w_held, aw_held_n, w_held_n;
    logic aw_rdy, w_rdy, aw_rdy_n, w_rdy_n, ar_rdy, ar_rdy_n, ar_hs, commit;
    logic [ADDR_W-1:2] aw_addr_q;
    logic [31:0] w_data_q, rdata_q, rdata_n;
    logic [3:0]  w_strb_q;
    logic [1:0]  bresp_q, bresp_n, rresp_q, rresp_n;
    logic [NUM_CH-1:0] irq_en, irq_en_n, in_wr, st_wr, out_rd;
    logic [NUM_CH-1:0] in_full, out_full, in_timeout;
    logic [31:0] out_word [NUM_CH];
    logic host_irq_q, irq_en_wr;
    dec_t wdec, rdec;

    assign wdec  = decode(aw_addr_q);
    assign rdec  = decode(s_axi_araddr[ADDR_W-1:2]);
    assign ar_hs = ar_rdy && s_axi_arvalid;

    always_comb begin
        w_state_n = w_state;
        aw_held_n = aw_held;
        w_held_n  = w_held;
        commit    = 1'b0;
        case (w_state)
            W_IDLE: begin
                // Commit happens the cycle after both halves are captured
                if (aw_held && w_held) begin
                    commit    = 1'b1;
                    aw_held_n = 1'b0;
                    w_held_n  = 1'b0;
                    w_state_n = W_RESP;
                end else begin
                    if (aw_rdy && s_axi_awvalid) aw_held_n = 1'b1;
                    if (w_rdy && s_axi_wvalid)   w_held_n  = 1'b1;
                end
            end
            W_RESP: if (s_axi_bready) w_state_n = W_IDLE;
        endcase
        aw_rdy_n = (w_state_n == W_IDLE) && !aw_held_n;
        w_rdy_n  = (w_state_n == W_IDLE) && !w_held_n;
    end

    always_comb begin
        in_wr     = '0;
        st_wr     = '0;
        bresp_n   = (wdec.kind == DEC_ERR) ? RESP_DECERR : RESP_OKAY;
        irq_en_wr = commit && (wdec.kind == DEC_IRQ_EN);
        irq_en_n  = irq_en;
        for (int i = 0; i < NUM_CH; i++)
            if (w_strb_q[i/8]) irq_en_n[i] = w_data_q[i];
        for (int c = 0; c < NUM_CH; c++) begin
            if (wdec.ch == 6'(c)) begin
                if (wdec.kind == DEC_IN) begin
                    in_wr[c] = commit;
                    if (in_full[c]) bresp_n = RESP_SLVERR;
                end
                if (wdec.kind == DEC_STATUS) st_wr[c] = commit;
            end
        end
    end

    always_comb begin
        r_state_n = r_state;
        case (r_state)
            R_IDLE: if (ar_hs) r_state_n = R_DATA;
            R_DATA: if (s_axi_rready) r_state_n = R_IDLE;
        endcase
        ar_rdy_n = (r_state_n == R_IDLE);
        out_rd   = '0;
        rdata_n  = '0;
        rresp_n  = RESP_OKAY;
        case (rdec.kind)
            DEC_ID:     rdata_n = ID_BASE | 32'(NUM_CH);
            DEC_IRQ_EN: rdata_n = 32'(irq_en);
            DEC_ERR:    rresp_n = RESP_DECERR;
            default:    ;
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            if (rdec.ch == 6'(c)) begin
                if (rdec.kind == DEC_STATUS)
                    rdata_n = {29'd0, in_timeout[c], out_full[c], in_full[c]};
                if (rdec.kind == DEC_OUT) begin
                    rdata_n   = out_full[c] ? out_word[c] : 32'd0;
                    out_rd[c] = ar_hs;
                end
            end
        end
    end

    always_ff @(posedge AxiBusClock or negedge xAxiBusReset_n) begin
        if (!xAxiBusReset_n) begin
            w_state    <= W_IDLE;
            r_state    <= R_IDLE;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_rdy     <= 1'b0;
            w_rdy      <= 1'b0;
            ar_rdy     <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            irq_en     <= '0;
            host_irq_q <= 1'b0;
        end else begin
            w_state <= w_state_n;
            r_state <= r_state_n;
            aw_held <= aw_held_n;
            w_held  <= w_held_n;
            aw_rdy  <= aw_rdy_n;
            w_rdy   <= w_rdy_n;
            ar_rdy  <= ar_rdy_n;
            if (aw_rdy && s_axi_awvalid) aw_addr_q <= s_axi_awaddr[ADDR_W-1:2];
            if (w_rdy && s_axi_wvalid) begin
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
            if (commit) bresp_q <= bresp_n;
            if (ar_hs) begin
                rdata_q <= rdata_n;
                rresp_q <= rresp_n;
            end
            if (irq_en_wr) irq_en <= irq_en_n;
            host_irq_q <= |((out_full | in_timeout) & irq_en);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        dfx_mailbox_channel #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_ch (
            .clk           (AxiBusClock),
            .rst_n         (xAxiBusReset_n),
            .in_wr         (in_wr[c]),
            .wr_data       (w_data_q),
            .wr_strb       (w_strb_q),
            .tmo_clr       (st_wr[c] && w_data_q[ST_IN_TIMEOUT] && w_strb_q[0]),
            .out_rd        (out_rd[c]),
            .mcu_in_data   (mcu_in_data[c*32 +: 32]),
            .mcu_in_valid  (mcu_in_valid[c]),
            .mcu_in_ready  (mcu_in_ready[c]),
            .mcu_out_data  (mcu_out_data[c*32 +: 32]),
            .mcu_out_valid (mcu_out_valid[c]),
            .mcu_out_ready (mcu_out_ready[c]),
            .in_full       (in_full[c]),
            .out_full      (out_full[c]),
            .in_timeout    (in_timeout[c]),
            .out_word      (out_word[c])
        );
    end

    assign s_axi_awready = aw_rdy;
    assign s_axi_wready  = w_rdy;
    assign s_axi_bvalid  = (w_state == W_RESP);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = ar_rdy;
    assign s_axi_rvalid  = (r_state == R_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign host_irq      = host_irq_q;

endmodule

// File: tb/tb_dfx_mailbox_bridge.sv
// Directed table-driven bench for dfx_mailbox_bridge (NUM_CH=4, TIMEOUT_CYC=16).
module tb_dfx_mailbox_bridge;

    localparam int NUM_CH = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam int ADDR_W = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
    logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic awready, wready, bvalid, arready, rvalid, host_irq;
    logic [31:0] wdata = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic [1:0]  bresp, rresp;
    logic [NUM_CH*32-1:0] mcu_in_data;
    logic [NUM_CH*32-1:0] mcu_out_data = '0;
    logic [NUM_CH-1:0] mcu_in_valid, mcu_out_ready;
    logic [NUM_CH-1:0] mcu_in_ready = '0, mcu_out_valid = '0;

    dfx_mailbox_bridge #(.NUM_CH(NUM_CH), .TIMEOUT_CYC(TIMEOUT_CYC), .ADDR_W(ADDR_W)) dut (
        .AxiBusClock(clk), .xAxiBusReset_n(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .mcu_in_data(mcu_in_data), .mcu_in_valid(mcu_in_valid), .mcu_in_ready(mcu_in_ready),
        .mcu_out_data(mcu_out_data), .mcu_out_valid(mcu_out_valid), .mcu_out_ready(mcu_out_ready),
        .host_irq(host_irq)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after the B handshake
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int n;
        bit aw_done, w_done, hs_aw, hs_w;
        awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(negedge clk); n++;
            if (hs_aw) begin awvalid = 0; aw_done = 1; end
            if (hs_w)  begin wvalid = 0;  w_done = 1;  end
        end
        awvalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        check("bvalid_seen", 32'(bvalid), 32'd1);
        resp = bresp;
        bready = 1;
        @(negedge clk);
        bready = 0;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1; n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        check("rvalid_seen", 32'(rvalid), 32'd1);
        d = rdata; resp = rresp;
        rready = 1;
        @(negedge clk);
        rready = 0;
    endtask

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    function automatic vec_t mkv(bit wr, logic [11:0] a, logic [31:0] d, logic [3:0] s,
                                 logic [1:0] r, logic [31:0] q);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.resp = r; v.rdata = q;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[21];
        logic [1:0]  r;
        logic [31:0] d;
        bit seen;

        vecs[0]  = mkv(0, 12'h400, 0, 0, 2'b00, 32'h4D42_0004);
        vecs[1]  = mkv(0, 12'h404, 0, 0, 2'b00, 32'h0);
        vecs[2]  = mkv(1, 12'h404, 32'hFFFF_FFFF, 4'hF, 2'b00, 0);
        vecs[3]  = mkv(0, 12'h404, 0, 0, 2'b00, 32'h0000_000F);
        vecs[4]  = mkv(1, 12'h404, 32'h0, 4'hF, 2'b00, 0);
        vecs[5]  = mkv(0, 12'h050, 0, 0, 2'b11, 32'h0);
        vecs[6]  = mkv(0, 12'h040, 0, 0, 2'b11, 32'h0);
        vecs[7]  = mkv(1, 12'h040, 32'h1234_5678, 4'hF, 2'b11, 0);
        vecs[8]  = mkv(0, 12'h408, 0, 0, 2'b11, 32'h0);
        vecs[9]  = mkv(0, 12'h3F0, 0, 0, 2'b11, 32'h0);
        vecs[10] = mkv(0, 12'h00C, 0, 0, 2'b00, 32'h0);
        vecs[11] = mkv(1, 12'h00C, 32'hFFFF_FFFF, 4'hF, 2'b00, 0);
        vecs[12] = mkv(0, 12'h008, 0, 0, 2'b00, 32'h0);
        vecs[13] = mkv(1, 12'h010, 32'hDEAD_BEEF, 4'hF, 2'b00, 0);
        vecs[14] = mkv(0, 12'h018, 0, 0, 2'b00, 32'h1);
        vecs[15] = mkv(1, 12'h010, 32'h1111_1111, 4'hF, 2'b10, 0);
        vecs[16] = mkv(0, 12'h004, 0, 0, 2'b00, 32'h0);
        vecs[17] = mkv(1, 12'h020, 32'hAABB_CCDD, 4'b0101, 2'b00, 0);
        vecs[18] = mkv(1, 12'h404, 32'h0000_0100, 4'b0010, 2'b00, 0);
        vecs[19] = mkv(0, 12'h404, 0, 0, 2'b00, 32'h0);
        vecs[20] = mkv(0, 12'hFFC, 0, 0, 2'b11, 32'h0);

        // Reset state
        #12;
        check("rst_awready", 32'(awready), 0);
        check("rst_wready", 32'(wready), 0);
        check("rst_arready", 32'(arready), 0);
        check("rst_bvalid_rvalid", {30'd0, bvalid, rvalid}, 0);
        check("rst_irq", 32'(host_irq), 0);
        check("rst_in_valid", 32'(mcu_in_valid), 0);
        check("rst_resp_data", {28'd0, bresp, rresp} | rdata, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        @(negedge clk); @(negedge clk);
        check("out_ready_idle", 32'(mcu_out_ready), 32'hF);

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
                check($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].resp));
            end else begin
                axi_read(vecs[i].addr, d, r);
                check($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].resp));
                check($sformatf("vec%0d_rdata", i), d, vecs[i].rdata);
            end
        end
        check("in_valid_after_table", 32'(mcu_in_valid), 32'h6);
        check("ch1_in_data", mcu_in_data[63:32], 32'hDEAD_BEEF);
        check("ch2_in_data_strb", mcu_in_data[95:64], 32'h00BB_00DD);

        // MCU consumes ch1/ch2, then a byte-merged refill of ch2
        mcu_in_ready = 4'b0110;
        @(negedge clk);
        mcu_in_ready = 0;
        check("in_valid_consumed", 32'(mcu_in_valid), 0);
        axi_write(12'h020, 32'h1122_3344, 4'b1010, r);
        check("ch2_merge_bresp", 32'(r), 0);
        check("ch2_merge_data", mcu_in_data[95:64], 32'h11BB_33DD);
        mcu_in_ready = 4'b0100;
        @(negedge clk);
        mcu_in_ready = 0;
        axi_write(12'h018, 32'h4, 4'hF, r);
        axi_write(12'h028, 32'h4, 4'hF, r);
        axi_read(12'h028, d, r);
        check("ch2_status_clean", d, 0);

        // Outbound push raises irq, read drains it
        axi_write(12'h404, 32'h1, 4'hF, r);
        mcu_out_data[31:0] = 32'h1234_5678;
        mcu_out_valid[0] = 1;
        @(negedge clk);
        mcu_out_valid[0] = 0;
        check("out_ready_full", 32'(mcu_out_ready[0]), 0);
        check("irq_not_yet", 32'(host_irq), 0);
        @(negedge clk);
        check("irq_set", 32'(host_irq), 1);
        axi_read(12'h004, d, r);
        check("out_read_data", d, 32'h1234_5678);
        check("irq_cleared", 32'(host_irq), 0);
        axi_read(12'h004, d, r);
        check("out_reread_zero", d, 0);

        // Push held during read-clear is blocked, then taken once
        mcu_out_data[31:0] = 32'hCAFE_F00D;
        mcu_out_valid[0] = 1;
        @(negedge clk);
        mcu_out_data[31:0] = 32'h0BAD_F00D;
        axi_read(12'h004, d, r);
        mcu_out_valid[0] = 0;
        check("out_first_word", d, 32'hCAFE_F00D);
        check("out_second_taken", 32'(mcu_out_ready[0]), 0);
        axi_read(12'h004, d, r);
        check("out_second_word", d, 32'h0BAD_F00D);

        // Inbound timeout on ch2 observed through host_irq
        axi_write(12'h404, 32'h4, 4'hF, r);
        @(negedge clk); @(negedge clk);
        check("irq_quiet_before_tmo", 32'(host_irq), 0);
        axi_write(12'h020, 32'h5555_AAAA, 4'hF, r);
        repeat (14) @(negedge clk);
        check("irq_before_cycle16", 32'(host_irq), 0);
        @(negedge clk);
        check("irq_at_cycle16", 32'(host_irq), 0);
        @(negedge clk);
        check("irq_after_tmo", 32'(host_irq), 1);
        axi_read(12'h028, d, r);
        check("ch2_status_tmo", d, 32'h5);
        axi_write(12'h028, 32'h4, 4'hF, r);
        check("w1c_bresp", 32'(r), 0);
        axi_read(12'h028, d, r);
        check("ch2_status_w1c", d, 32'h1);
        check("irq_after_w1c", 32'(host_irq), 0);

        // W three cycles ahead of AW, bready held low five cycles
        bready = 0;
        wdata = 32'h0A0B_0C0D; wstrb = 4'hF; wvalid = 1;
        check("w_first_ready", 32'(wready), 1);
        @(negedge clk);
        wvalid = 0;
        check("w_held_ready_low", 32'(wready), 0);
        @(negedge clk); @(negedge clk);
        awaddr = 12'h030; awvalid = 1;
        check("aw_late_ready", 32'(awready), 1);
        @(negedge clk);
        awvalid = 0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bvalid_hold%0d", k), {29'd0, bvalid, bresp}, 32'h4);
            @(negedge clk);
        end
        check("aw_blocked_in_resp", 32'(awready), 0);
        bready = 1;
        @(negedge clk);
        bready = 0;
        check("bvalid_dropped", 32'(bvalid), 0);
        check("ch3_in", {31'd0, mcu_in_valid[3]} ^ mcu_in_data[127:96], 32'h0A0B_0C0C);

        // Reset asserted while a read response is pending
        araddr = 12'h400; arvalid = 1;
        for (int n = 0; n < 50 && !arready; n++) @(negedge clk);
        @(negedge clk);
        arvalid = 0;
        check("rvalid_pending", 32'(rvalid), 1);
        #2 rst_n = 0;
        #1;
        check("rst_async_rvalid", 32'(rvalid), 0);
        check("rst_async_rdata", rdata, 0);
        check("rst_async_inval", 32'(mcu_in_valid), 0);
        @(negedge clk);
        rst_n = 1;
        rready = 1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            seen |= rvalid | bvalid;
        end
        rready = 0;
        check("no_late_response", 32'(seen), 0);
        axi_read(12'h400, d, r);
        check("id_after_reset", d, 32'h4D42_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
